// File: rtl/tt_sweep_checker.sv
// tt_sweep_checker
// Sweeps every input vector of an external N-input combinational circuit,
// holds each one for SETTLE cycles, samples the circuit output and builds the
// observed truth table. The observed table is compared row by row against an
// expected table that is latched at start. Row i lives in table bit
// [TT_W-1-i], so row 0 is the MSB.
module tt_sweep_checker #(
    parameter int N_IN   = 3,
    parameter int SETTLE = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [(2**N_IN)-1:0]   expected_tt,
    output logic [N_IN-1:0]        stim,
    input  logic                   dut_out,
    output logic                   busy,
    output logic                   done,
    output logic [(2**N_IN)-1:0]   observed_tt,
    output logic [N_IN:0]          mismatch_cnt,
    output logic                   pass
);

    localparam int TT_W  = 2**N_IN;
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t            state_r;
    logic [N_IN-1:0]   idx_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [TT_W-1:0]   exp_r;

    logic [N_IN-1:0]   row_s;
    logic              miss_s;
    logic [N_IN:0]     mm_next_s;
    logic              last_s;
    logic              settle_end_s;

    // Row position, per-row compare and end-of-phase flags for the current index
    always_comb begin
        row_s        = ~idx_r;                        // TT_W-1-idx for an N_IN-bit index
        miss_s       = (dut_out != exp_r[row_s]);
        mm_next_s    = mismatch_cnt + {{N_IN{1'b0}}, miss_s};
        last_s       = (idx_r == N_IN'(TT_W - 1));
        settle_end_s = (cnt_r == CNT_W'(SETTLE - 1));
    end

    // Sweep sequencer with all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            idx_r        <= {N_IN{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            exp_r        <= {TT_W{1'b0}};
            stim         <= {N_IN{1'b0}};
            busy         <= 1'b0;
            done         <= 1'b0;
            observed_tt  <= {TT_W{1'b0}};
            mismatch_cnt <= {(N_IN+1){1'b0}};
            pass         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // abort beats a simultaneous start
                    if (start && !abort) begin
                        state_r      <= ST_DRIVE;
                        exp_r        <= expected_tt;
                        observed_tt  <= {TT_W{1'b0}};
                        mismatch_cnt <= {(N_IN+1){1'b0}};
                        pass         <= 1'b0;
                        idx_r        <= {N_IN{1'b0}};
                        cnt_r        <= {CNT_W{1'b0}};
                        stim         <= {N_IN{1'b0}};
                        busy         <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_DRIVE: begin
                    if (abort) begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                        pass    <= 1'b0;
                        stim    <= {N_IN{1'b0}};
                        idx_r   <= {N_IN{1'b0}};
                        cnt_r   <= {CNT_W{1'b0}};
                    end else if (settle_end_s) begin
                        state_r <= ST_SAMPLE;
                        cnt_r   <= {CNT_W{1'b0}};
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_SAMPLE: begin
                    if (abort) begin
                        // partial table and count are kept as they are
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                        pass    <= 1'b0;
                        stim    <= {N_IN{1'b0}};
                        idx_r   <= {N_IN{1'b0}};
                        cnt_r   <= {CNT_W{1'b0}};
                    end else begin
                        observed_tt[row_s] <= dut_out;
                        mismatch_cnt       <= mm_next_s;
                        if (last_s) begin
                            // verdict includes the final row's compare
                            state_r <= ST_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            pass    <= (mm_next_s == {(N_IN+1){1'b0}});
                            stim    <= {N_IN{1'b0}};
                            idx_r   <= {N_IN{1'b0}};
                        end else begin
                            state_r <= ST_DRIVE;
                            idx_r   <= idx_r + N_IN'(1);
                            stim    <= idx_r + N_IN'(1);
                        end
                    end
                end
                ST_DONE: begin
                    // start and abort are both ignored here
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    stim    <= {N_IN{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Directed bench for tt_sweep_checker with N_IN=3, SETTLE=2.
// The circuit under test is a truth-table lookup driven by stim.
module tb_tt_sweep_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] expected_tt;
    logic [2:0] stim;
    logic       dut_out;
    logic       busy;
    logic       done;
    logic [7:0] observed_tt;
    logic [3:0] mismatch_cnt;
    logic       pass;
    logic [7:0] tbl;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Modelled circuit: row i of tbl is bit [7-i]
    assign dut_out = tbl[~stim];

    tt_sweep_checker #(.N_IN(3), .SETTLE(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .expected_tt  (expected_tt),
        .stim         (stim),
        .dut_out      (dut_out),
        .busy         (busy),
        .done         (done),
        .observed_tt  (observed_tt),
        .mismatch_cnt (mismatch_cnt),
        .pass         (pass)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start at edge 0, check every cycle 1..24, return in the done cycle (25).
    // poke=1 pulses start and flips expected_tt in cycle 12.
    task automatic do_sweep(input logic [7:0] e, input bit poke);
        expected_tt = e;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            if (poke && c == 12) begin
                start = 1'b1;
                expected_tt = ~e;
            end else if (poke && c == 13) begin
                start = 1'b0;
            end
            chk("busy_run", busy, 1);
            chk("done_early", done, 0);
            chk("stim_hold", stim, (c - 1) / 3);
            tick();
        end
        start = 1'b0;
        chk("done_pulse", done, 1);
        chk("busy_at_done", busy, 0);
        chk("stim_at_done", stim, 0);
        expected_tt = e;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; expected_tt = 8'h00; tbl = 8'h8E;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_stim", stim, 0);
        chk("rst_obs", observed_tt, 0);
        chk("rst_mm", mismatch_cnt, 0);
        chk("rst_pass", pass, 0);
        rst = 1'b0;
        tick();

        // Matching sweep
        do_sweep(8'h8E, 1'b0);
        chk("t1_obs", observed_tt, 8'h8E);
        chk("t1_mm", mismatch_cnt, 0);
        chk("t1_pass", pass, 1);
        tick();
        chk("t1_done_clr", done, 0);
        chk("t1_obs_held", observed_tt, 8'h8E);
        chk("t1_pass_held", pass, 1);
        chk("t1_stim_idle", stim, 0);

        // One differing row
        do_sweep(8'h8F, 1'b0);
        chk("t2_obs", observed_tt, 8'h8E);
        chk("t2_mm", mismatch_cnt, 1);
        chk("t2_pass", pass, 0);
        tick();

        // Output tied low, all rows expected high
        tbl = 8'h00;
        do_sweep(8'hFF, 1'b0);
        chk("t3_obs", observed_tt, 8'h00);
        chk("t3_mm", mismatch_cnt, 8);
        chk("t3_pass", pass, 0);
        tick();

        // Reset in cycle 10 of a sweep
        tbl = 8'h8E;
        expected_tt = 8'h8E;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        chk("t4_busy_pre", busy, 1);
        rst = 1'b1;
        #1;
        chk("t4_busy", busy, 0);
        chk("t4_done", done, 0);
        chk("t4_stim", stim, 0);
        chk("t4_obs", observed_tt, 0);
        chk("t4_mm", mismatch_cnt, 0);
        chk("t4_pass", pass, 0);
        tick();
        tick();
        chk("t4_no_done", done, 0);
        rst = 1'b0;
        tick();
        do_sweep(8'h8E, 1'b0);
        chk("t4_re_obs", observed_tt, 8'h8E);
        chk("t4_re_pass", pass, 1);
        tick();

        // Abort in cycle 7: row 0 sampled (mismatch vs 0x0E), row 1 sampled
        expected_tt = 8'h0E;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        chk("t5_busy_pre", busy, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_pass", pass, 0);
        chk("t5_stim", stim, 0);
        chk("t5_obs", observed_tt, 8'h80);
        chk("t5_mm", mismatch_cnt, 1);
        repeat (3) tick();
        chk("t5_no_done", done, 0);
        chk("t5_obs_held", observed_tt, 8'h80);
        chk("t5_mm_held", mismatch_cnt, 1);

        // Mid-sweep start and expected_tt change are ignored
        do_sweep(8'h8E, 1'b1);
        chk("t5b_obs", observed_tt, 8'h8E);
        chk("t5b_mm", mismatch_cnt, 0);
        chk("t5b_pass", pass, 1);
        tick();
        chk("t5b_no_restart", busy, 0);

        // start with abort in IDLE does nothing
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("t6_sa_busy", busy, 0);
        tick();
        chk("t6_sa_busy2", busy, 0);
        chk("t6_sa_pass_held", pass, 1);

        // start in the done cycle ignored, one cycle later accepted
        do_sweep(8'h8F, 1'b0);
        expected_tt = 8'h8E;
        start = 1'b1;
        tick();
        chk("t6_done_start_ign", busy, 0);
        tick();
        start = 1'b0;
        chk("t6_late_start_busy", busy, 1);
        chk("t6_late_obs_clr", observed_tt, 0);
        chk("t6_late_mm_clr", mismatch_cnt, 0);
        chk("t6_late_pass_clr", pass, 0);
        repeat (23) tick();
        chk("t6_late_done_early", done, 0);
        tick();
        chk("t6_late_done", done, 1);
        chk("t6_late_obs", observed_tt, 8'h8E);
        chk("t6_late_pass", pass, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tt_sweep_checker.md
Name: tt_sweep_checker

Overview:
Parametrised truth-table verifier for N-input genetic-logic gate netlists, such as the 3-input NOR/NOT designs scored by the circuit-scoring flow. On start it drives every input vector onto an external combinational circuit and waits a programmable settle time. It then samples the circuit output, assembles the observed truth table, compares it bit-by-bit against an expected table and reports the mismatch count and pass/fail. It is the sequential, N-input successor to the fixed per-function 3-input netlists.

Parameters:
N_IN, 3, number of circuit inputs (1..8); TT_W = 2**N_IN is derived locally
SETTLE, 2, cycles each vector is held before sampling (>=1)

Ports:
clk  input  1  clock, rising-edge
rst  input  1  asynchronous, active-high reset
start  input  1  request a sweep; accepted only in IDLE
abort  input  1  synchronous abort of a running sweep
expected_tt  input  TT_W  expected truth table, latched at start
stim  output  N_IN  input vector to the circuit under test; stim[N_IN-1] drives in1, stim[0] drives the last input
dut_out  input  1  circuit output
busy  output  1  sweep in progress
done  output  1  one-cycle pulse at sweep completion
observed_tt  output  TT_W  captured truth table
mismatch_cnt  output  N_IN+1  number of differing rows (0..TT_W)
pass  output  1  1 when the last completed sweep had mismatch_cnt==0

Behaviour:
- Bit ordering: the table bit for vector i is bit [TT_W-1-i]. Vector 0 is the MSB, so the table reads row 000 first. Example: 0x8E gives row i = 1,0,0,0,1,1,1,0 for i = 0..7.
- Reset (async): state IDLE. stim=0, busy=0, done=0, observed_tt=0, mismatch_cnt=0, pass=0, internal index/settle counters=0. A reset mid-sweep produces no done pulse.
- FSM states and transitions:
  - IDLE: start=1 and abort=0 -> DRIVE. On acceptance: latch expected_tt, clear observed_tt, mismatch_cnt and pass, set idx=0 and stim=0.
  - DRIVE: stim=idx for SETTLE cycles -> SAMPLE.
  - SAMPLE (1 cycle): observed_tt[TT_W-1-idx] <= dut_out. If dut_out != latched expected bit, mismatch_cnt += 1. If idx==TT_W-1 -> DONE; else idx += 1 and stim updates -> DRIVE.
  - DONE (1 cycle): done=1, pass=(mismatch_cnt==0 including the final row), stim <= 0 -> IDLE.
- busy=1 in DRIVE and SAMPLE, 0 in IDLE and DONE.
- Latency: start sampled at edge 0. busy is high during cycles 1..TT_W*(SETTLE+1). done is high in cycle TT_W*(SETTLE+1)+1. For N_IN=3, SETTLE=2: done in cycle 25.
- start while busy or during DONE is ignored; the earliest restart is the cycle after done.
- abort in DRIVE/SAMPLE: IDLE next cycle, no done, pass=0, stim=0. Partial observed_tt and mismatch_cnt are held.
- abort in IDLE or DONE has no effect. abort together with start in IDLE: abort wins and start is ignored.
- Changes to expected_tt after acceptance have no effect.
- Results are held stable until the next accepted start or reset.
- mismatch_cnt saturates by construction: max value TT_W fits in N_IN+1 bits.
- dut_out is sampled directly. SETTLE must cover the circuit's propagation delay; no synchroniser.

Test Plan:
- N_IN=3, SETTLE=2, dut_out from the 0x8E NOR/NOT netlist, expected_tt=0x8E, start at cycle 0 -> done in cycle 25 only, observed_tt=0x8E, mismatch_cnt=0, pass=1, stim=0 afterwards.
- Same circuit, expected_tt=0x8F -> observed_tt=0x8E, mismatch_cnt=1, pass=0.
- dut_out tied 0, expected_tt=0xFF -> observed_tt=0x00, mismatch_cnt=8, pass=0. Also check stim holds each value 0..7 for exactly 3 cycles.
- Assert rst in cycle 10 mid-sweep -> all outputs 0 immediately, no done. Release, then start again -> normal completion in 25 cycles.
- abort in cycle 7 -> busy=0 in cycle 8, no done, pass=0. start at cycle 12 while busy is ignored; expected_tt toggled mid-sweep does not change the result.
- start and abort both high in IDLE -> nothing starts. start in the done cycle is ignored; start one cycle later is accepted.
